// File: rtl/ex_stage_md.sv
// Execute stage: 12-op ALU, iterative restoring divider, sub-word store byte enables,
// alignment check, flush, and a forwarding port for the ID hazard logic.

module ex_alu #(
  parameter int DATA_W = 32
) (
  input  logic [11:0]       alu_op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic [DATA_W-1:0] alu_result
);
  localparam int SH_W = $clog2(DATA_W);

  logic              do_sub;
  logic [DATA_W:0]   add_ext;
  logic              slt;
  logic              sltu;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] sll_res;
  logic [DATA_W-1:0] srl_res;
  logic [DATA_W-1:0] sra_res;

  // One adder serves add, sub and both compares; carry-out clear means src1 < src2 unsigned.
  assign do_sub  = alu_op[1] | alu_op[2] | alu_op[3];
  assign add_ext = {1'b0, src1} + {1'b0, (do_sub ? ~src2 : src2)} + {{DATA_W{1'b0}}, do_sub};
  assign slt     = (src1[DATA_W-1] & ~src2[DATA_W-1])
                 | (~(src1[DATA_W-1] ^ src2[DATA_W-1]) & add_ext[DATA_W-1]);
  assign sltu    = ~add_ext[DATA_W];
  assign shamt   = src2[SH_W-1:0];
  assign sll_res = src1 << shamt;
  assign srl_res = src1 >> shamt;
  assign sra_res = $unsigned($signed(src1) >>> shamt);

  always_comb begin
    alu_result = '0;
    if (alu_op[0] | alu_op[1]) alu_result = alu_result | add_ext[DATA_W-1:0];
    if (alu_op[2])             alu_result = alu_result | {{(DATA_W-1){1'b0}}, slt};
    if (alu_op[3])             alu_result = alu_result | {{(DATA_W-1){1'b0}}, sltu};
    if (alu_op[4])             alu_result = alu_result | (src1 & src2);
    if (alu_op[5])             alu_result = alu_result | ~(src1 | src2);
    if (alu_op[6])             alu_result = alu_result | (src1 | src2);
    if (alu_op[7])             alu_result = alu_result | (src1 ^ src2);
    if (alu_op[8])             alu_result = alu_result | sll_res;
    if (alu_op[9])             alu_result = alu_result | srl_res;
    if (alu_op[10])            alu_result = alu_result | sra_res;
    if (alu_op[11])            alu_result = alu_result | src2;
  end
endmodule

module ex_stage_md #(
  parameter int DATA_W  = 32,
  parameter int DEST_W  = 5,
  parameter int DIV_BPC = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          id_to_ex_valid,
  input  logic [4*DATA_W+23+DEST_W-1:0] id_to_ex_bus,
  output logic                          ex_allow_in,
  input  logic                          me_allow_in,
  output logic                          ex_to_me_valid,
  output logic [2*DATA_W+12+DEST_W-1:0] ex_to_me_bus,
  output logic                          data_sram_en,
  output logic [DATA_W/8-1:0]           data_sram_we,
  output logic [DATA_W-1:0]             data_sram_addr,
  output logic [DATA_W-1:0]             data_sram_wdata,
  output logic [DEST_W-1:0]             ex_dest,
  output logic                          ex_fwd_valid,
  output logic [DATA_W-1:0]             ex_fwd_data
);
  localparam int IN_W  = 4*DATA_W+23+DEST_W;
  localparam int PAD_W = 4;
  localparam int DIV_N = DATA_W/DIV_BPC;
  localparam int CNT_W = $clog2(DIV_N+1);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Handshake: a transfer happens on an edge where the producer's valid and the
  // consumer's allow_in are both high; valid never depends on the consumer's allow_in.
  logic            ex_valid;
  logic [IN_W-1:0] bus_r;
  logic            ready_go;
  logic            hs;

  logic [11:0]       alu_op;
  logic [2:0]        md_op;
  logic [1:0]        mem_size;
  logic              mem_sign;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rj_value;
  logic [DATA_W-1:0] rkd_value;
  logic              src1_is_pc;
  logic              src2_is_imm;
  logic              res_from_mem;
  logic              gr_we;
  logic              mem_we;
  logic [DEST_W-1:0] dest;

  assign {alu_op, md_op, mem_size, mem_sign, pc, imm, rj_value, rkd_value,
          src1_is_pc, src2_is_imm, res_from_mem, gr_we, mem_we, dest} = bus_r;

  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [DATA_W-1:0] alu_result;

  assign src1 = src1_is_pc  ? pc  : rj_value;
  assign src2 = src2_is_imm ? imm : rkd_value;

  ex_alu #(.DATA_W(DATA_W)) u_alu (
    .alu_op     (alu_op),
    .src1       (src1),
    .src2       (src2),
    .alu_result (alu_result)
  );

  div_state_t        div_state;
  div_state_t        div_next;
  logic [CNT_W-1:0]  div_cnt;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] div_q;
  logic [DATA_W-1:0] div_r;

  assign ready_go       = ~md_op[2] | (div_state == DIV_DONE);
  assign ex_allow_in    = ~ex_valid | (ready_go & me_allow_in);
  assign ex_to_me_valid = ex_valid & ready_go & ~flush;
  assign hs             = ex_to_me_valid & me_allow_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      bus_r    <= '0;
    end else begin
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (ex_allow_in) begin
        ex_valid <= id_to_ex_valid;
      end
      if (ex_allow_in && id_to_ex_valid) begin
        bus_r <= id_to_ex_bus;
      end
    end
  end

  // Divider works on magnitudes; md_op[1] selects unsigned, md_op[0] selects remainder.
  logic              div_signed;
  logic              dvd_neg;
  logic              dsr_neg;
  logic              dsr_zero;
  logic [DATA_W-1:0] dvd_mag;
  logic [DATA_W-1:0] dsr_mag;
  logic [DATA_W-1:0] quo_step;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;

  assign div_signed = ~md_op[1];
  assign dvd_neg    = div_signed & rj_value[DATA_W-1];
  assign dsr_neg    = div_signed & rkd_value[DATA_W-1];
  assign dsr_zero   = (rkd_value == '0);
  assign dvd_mag    = dvd_neg ? (~rj_value + 1'b1) : rj_value;
  assign dsr_mag    = dsr_neg ? (~rkd_value + 1'b1) : rkd_value;

  always_comb begin
    quo_step = quo;
    rem_step = rem;
    trial    = '0;
    diff     = '0;
    for (int i = 0; i < DIV_BPC; i++) begin
      trial    = {rem_step, quo_step[DATA_W-1]};
      diff     = trial - {1'b0, dsr_mag};
      quo_step = {quo_step[DATA_W-2:0], ~diff[DATA_W]};
      rem_step = diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
    end
  end

  // Signs are applied once, on the last iteration, so RUN only ever handles magnitudes.
  always_comb begin
    q_fix = (dvd_neg ^ dsr_neg) ? (~quo_step + 1'b1) : quo_step;
    r_fix = dvd_neg ? (~rem_step + 1'b1) : rem_step;
    if (dsr_zero) begin
      q_fix = '1;
      r_fix = rj_value;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_state <= DIV_IDLE;
    end else begin
      div_state <= div_next;
    end
  end

  always_comb begin
    div_next = div_state;
    case (div_state)
      DIV_IDLE: if (ex_valid && md_op[2]) div_next = DIV_RUN;
      DIV_RUN:  if (div_cnt == CNT_W'(1)) div_next = DIV_DONE;
      DIV_DONE: if (hs) div_next = DIV_IDLE;
      default:  div_next = DIV_IDLE;
    endcase
    if (flush) div_next = DIV_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      quo     <= '0;
      rem     <= '0;
      div_q   <= '0;
      div_r   <= '0;
    end else if (div_state == DIV_IDLE && div_next == DIV_RUN) begin
      div_cnt <= CNT_W'(DIV_N);
      quo     <= dvd_mag;
      rem     <= '0;
    end else if (div_state == DIV_RUN) begin
      div_cnt <= div_cnt - CNT_W'(1);
      quo     <= quo_step;
      rem     <= rem_step;
      if (div_cnt == CNT_W'(1)) begin
        div_q <= q_fix;
        div_r <= r_fix;
      end
    end
  end

  logic [DATA_W-1:0]   ex_result;
  logic                mem_op;
  logic                ale;
  logic [DATA_W/8-1:0] byte_mask;
  logic [DATA_W-1:0]   store_data;

  assign ex_result = md_op[2] ? (md_op[0] ? div_r : div_q) : alu_result;
  assign mem_op    = mem_we | res_from_mem;
  assign ale       = mem_op & (((mem_size == 2'b01) & alu_result[0])
                             | (mem_size[1] & (alu_result[1:0] != 2'b00)));

  always_comb begin
    byte_mask  = '1;
    store_data = rkd_value;
    if (mem_size == 2'b00) begin
      byte_mask  = 4'b0001 << alu_result[1:0];
      store_data = {4{rkd_value[7:0]}};
    end else if (mem_size == 2'b01) begin
      byte_mask  = 4'b0011 << {alu_result[1], 1'b0};
      store_data = {2{rkd_value[15:0]}};
    end
  end

  // Strobe rides on the handshake so a stalled access is issued exactly once.
  assign data_sram_en    = hs & mem_op & ~ale;
  assign data_sram_we    = (data_sram_en & mem_we) ? byte_mask : '0;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = store_data;

  assign ex_dest      = (ex_valid & gr_we) ? dest : '0;
  assign ex_fwd_valid = ex_valid & ready_go & gr_we & ~res_from_mem;
  assign ex_fwd_data  = ex_result;

  // Top nibble of the ME bus is reserved and driven to zero.
  assign ex_to_me_bus = {{PAD_W{1'b0}}, pc, ex_result, mem_size, mem_sign, alu_result[1:0],
                         ale, res_from_mem, gr_we, dest};
endmodule
